iroot_seq: RTL

Sequential integer root unit computing floor(sqrt(x)) or floor(cbrt(x)) of a WIDTH-bit unsigned operand, with the root mode selected per operation. It is the parametrised successor to the fixed 8-bit cube-root core in the lab_2 arithmetic datapath and uses the same start/busy handshake. It adds a done pulse and result holding, and can optionally report a remainder.

---
 rtl/iroot_pkg.sv | 27 ++
 rtl/iroot_if.sv | 31 +++
 rtl/iroot_step.sv | 42 ++++
 rtl/iroot_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/iroot_pkg.sv
// iroot_pkg: shared types and constants for the sequential integer root unit.
// Mode encoding, FSM state type, and the per-mode iteration count and starting shift.
package iroot_pkg;

  localparam logic MODE_SQRT = 1'b0;
  localparam logic MODE_CBRT = 1'b1;

  // Counter and shift widths cover WIDTH up to 32 (at most 16 iterations, shift at most 30).
  localparam int CW = 6;
  localparam int SW = 6;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // One root bit per iteration: sqrt consumes 2-bit groups, cbrt consumes 3-bit groups.
  function automatic int iter_count(input logic m, input int w);
    return (m == MODE_CBRT) ? (w + 2) / 3 : (w + 1) / 2;
  endfunction

  // The shift aligns the trial term with the most significant group of the operand.
  function automatic int init_shift(input logic m, input int w);
    return (m == MODE_CBRT) ? 3 * (iter_count(m, w) - 1) : 2 * (iter_count(m, w) - 1);
  endfunction

endpackage

// File: rtl/iroot_if.sv
// iroot_if: start/busy/done handshake and data bus of the integer root unit.
// The rem signal exists only when IROOT_REM_EN is defined.
interface iroot_if #(
  parameter int WIDTH = 8
);
  logic             start_c;
  logic             mode;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef IROOT_REM_EN
  logic [WIDTH-1:0] rem;
`endif

  modport master (
    output start_c, mode, x,
    input  busy, done, result
`ifdef IROOT_REM_EN
    , rem
`endif
  );

  modport slave (
    input  start_c, mode, x,
    output busy, done, result
`ifdef IROOT_REM_EN
    , rem
`endif
  );
endinterface

// File: rtl/iroot_step.sv
// iroot_step: one combinational restoring iteration of the digit-by-digit root.
// The trial term is built in a width large enough that it can never wrap; a term
// that does not fit the WIDTH+2 bit residual is simply never subtracted.
module iroot_step
  import iroot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] i_res,
  input  logic [WIDTH-1:0] i_y,
  input  logic [SW-1:0]    i_s,
  input  logic             i_mode,
  output logic [WIDTH+1:0] o_res,
  output logic [WIDTH-1:0] o_y
);

  // y stays below 2^(WIDTH+1) after doubling, so 3y(y+1)+1 shifted by at most
  // WIDTH-1 stays below 2^(3*WIDTH+3).
  localparam int TW = 3 * WIDTH + 4;

  logic [TW-1:0] w_y2;
  logic [TW-1:0] w_base;
  logic [TW-1:0] w_t;
  logic          w_fit;
  logic          w_take;

  // Double y, form the trial term, and subtract it only when it fits and does not exceed r.
  always_comb begin
    w_y2 = TW'(i_y) << 1;
    if (i_mode == MODE_CBRT) begin
      w_base = TW'(3) * w_y2 * (w_y2 + TW'(1)) + TW'(1);
    end else begin
      w_base = (w_y2 << 1) + TW'(1);
    end
    w_t    = w_base << i_s;
    w_fit  = (w_t[TW-1:WIDTH+2] == '0);
    w_take = w_fit && (w_t[WIDTH+1:0] <= i_res);
    o_res  = w_take ? (i_res - w_t[WIDTH+1:0]) : i_res;
    o_y    = w_take ? (w_y2[WIDTH-1:0] + WIDTH'(1)) : w_y2[WIDTH-1:0];
  end

endmodule

// File: rtl/iroot_seq.sv
// iroot_seq: sequential floor(sqrt(x)) / floor(cbrt(x)), one root bit per cycle.
// Optional remainder output enabled by IROOT_REM_EN.
//
//   state | meaning
//   IDLE  | waiting for start_c; result/rem hold the last completed values
//   CALC  | iterating; busy=1, start_c and operand inputs ignored
module iroot_seq
  import iroot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic   clk_c,
  input logic   rst_c,
  iroot_if.slave bus
);

  localparam int N_SQ = iter_count(MODE_SQRT, WIDTH);
  localparam int N_CB = iter_count(MODE_CBRT, WIDTH);
  localparam int S_SQ = init_shift(MODE_SQRT, WIDTH);
  localparam int S_CB = init_shift(MODE_CBRT, WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_finish;
  logic [WIDTH+1:0] r_res;
  logic [WIDTH-1:0] r_y;
  logic [SW-1:0]    r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_mode;
  logic [WIDTH+1:0] w_res_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
`ifdef IROOT_REM_EN
  logic [WIDTH-1:0] r_rem;
`endif

  iroot_step #(.WIDTH(WIDTH)) u_step (
    .i_res  (r_res),
    .i_y    (r_y),
    .i_s    (r_s),
    .i_mode (r_mode),
    .o_res  (w_res_nxt),
    .o_y    (w_y_nxt)
  );

  // Next-state decode; the counter holds the number of iterations still to run.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start_c) begin
          w_state_nxt = CALC;
          w_load      = 1'b1;
        end
      end
      CALC: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_c or negedge rst_c) begin
    if (!rst_c) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Working registers: latch the operation on acceptance, then advance one iteration per cycle.
  always_ff @(posedge clk_c or negedge rst_c) begin
    if (!rst_c) begin
      r_res  <= '0;
      r_y    <= '0;
      r_s    <= '0;
      r_cnt  <= '0;
      r_mode <= MODE_SQRT;
    end else if (w_load) begin
      r_res  <= {2'b00, bus.x};
      r_y    <= '0;
      r_mode <= bus.mode;
      r_s    <= (bus.mode == MODE_CBRT) ? SW'(S_CB) : SW'(S_SQ);
      r_cnt  <= (bus.mode == MODE_CBRT) ? CW'(N_CB) : CW'(N_SQ);
    end else if (r_state == CALC) begin
      r_res  <= w_res_nxt;
      r_y    <= w_y_nxt;
      r_s    <= r_s - ((r_mode == MODE_CBRT) ? SW'(3) : SW'(2));
      r_cnt  <= r_cnt - CW'(1);
    end
  end

  // Output registers update only on the final iteration so no partial root is ever visible.
  always_ff @(posedge clk_c or negedge rst_c) begin
    if (!rst_c) begin
      r_done   <= 1'b0;
      r_result <= '0;
`ifdef IROOT_REM_EN
      r_rem    <= '0;
`endif
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_result <= w_y_nxt;
`ifdef IROOT_REM_EN
        r_rem    <= w_res_nxt[WIDTH-1:0];
`endif
      end
    end
  end

  assign bus.busy   = (r_state == CALC);
  assign bus.done   = r_done;
  assign bus.result = r_result;
`ifdef IROOT_REM_EN
  assign bus.rem    = r_rem;
`endif

endmodule
